// File: rtl/rrf_free_list.sv
// Retirement register map plus circular free list of physical registers.
// Commits push displaced mappings at the tail, rename pops at the head, mispredict reclaims in-flight regs.
module rrf_free_list #(
  parameter int SS        = 2,
  parameter int SS_BITS   = 1,
  parameter int NUM_ARCH  = 32,
  parameter int NUM_PHYS  = 64,
  parameter int FL_DEPTH  = NUM_PHYS - NUM_ARCH,
  parameter int FL_BITS   = $clog2(FL_DEPTH),
  parameter int ARCH_BITS = $clog2(NUM_ARCH),
  parameter int PHYS_BITS = $clog2(NUM_PHYS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SS_BITS:0]     commit_cnt,
  input  logic [ARCH_BITS-1:0] rrf_arch_reg [SS],
  input  logic [PHYS_BITS-1:0] rrf_phys_reg [SS],
  input  logic                 mispredict,
  input  logic [SS_BITS:0]     alloc_cnt,
  output logic [PHYS_BITS-1:0] alloc_phys [SS],
  output logic [FL_BITS:0]     free_count,
  output logic [PHYS_BITS-1:0] rrf_map [NUM_ARCH]
);

  localparam logic [FL_BITS:0] DEPTH_PTR = (FL_BITS+1)'(FL_DEPTH);

  logic [PHYS_BITS-1:0] map_q [NUM_ARCH];
  logic [PHYS_BITS-1:0] map_d [NUM_ARCH];
  logic [PHYS_BITS-1:0] fl_q  [FL_DEPTH];
  logic [PHYS_BITS-1:0] fl_d  [FL_DEPTH];
  logic [FL_BITS:0]     head_q, head_d;
  logic [FL_BITS:0]     tail_q, tail_d;
  logic [FL_BITS:0]     count;
  logic [FL_BITS-1:0]   wr_idx;
  logic [SS_BITS:0]     push_cnt;
  logic                 alloc_ok;

  // Pointers carry an extra wrap bit, so tail - head spans 0..FL_DEPTH without ambiguity.
  assign count      = tail_q - head_q;
  assign free_count = count;
  // An over-sized request is dropped entirely rather than popping past the tail.
  assign alloc_ok   = ((FL_BITS+1)'(alloc_cnt) <= count);

  always_comb begin
    map_d    = map_q;
    fl_d     = fl_q;
    push_cnt = '0;
    wr_idx   = tail_q[FL_BITS-1:0];
    // Lanes read map_d so a later lane displaces an earlier lane's phys for the same arch.
    for (int i = 0; i < SS; i++) begin
      if (((SS_BITS+1)'(i) < commit_cnt) && (rrf_arch_reg[i] != '0)) begin
        wr_idx                 = tail_q[FL_BITS-1:0] + FL_BITS'(push_cnt);
        fl_d[wr_idx]           = map_d[rrf_arch_reg[i]];
        map_d[rrf_arch_reg[i]] = rrf_phys_reg[i];
        push_cnt               = push_cnt + (SS_BITS+1)'(1);
      end
    end
    tail_d = tail_q + (FL_BITS+1)'(push_cnt);
    // Slots between the old tail and head hold exactly the squashed allocations.
    if (mispredict) begin
      head_d = tail_d - DEPTH_PTR;
    end else if (alloc_ok) begin
      head_d = head_q + (FL_BITS+1)'(alloc_cnt);
    end else begin
      head_d = head_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= DEPTH_PTR;
      for (int i = 0; i < NUM_ARCH; i++) begin
        map_q[i] <= PHYS_BITS'(i);
      end
      for (int j = 0; j < FL_DEPTH; j++) begin
        fl_q[j] <= PHYS_BITS'(NUM_ARCH + j);
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      map_q  <= map_d;
      fl_q   <= fl_d;
    end
  end

  for (genvar gi = 0; gi < SS; gi++) begin : g_alloc
    logic [FL_BITS-1:0] rd_idx;
    assign rd_idx         = head_q[FL_BITS-1:0] + FL_BITS'(gi);
    assign alloc_phys[gi] = fl_q[rd_idx];
  end

  for (genvar gi = 0; gi < NUM_ARCH; gi++) begin : g_map
    assign rrf_map[gi] = map_q[gi];
  end

endmodule

// File: tb/tb_rrf_free_list.sv
// Directed and random checks of rrf_free_list against a reference model with unbounded pointers.
module tb_rrf_free_list;
  localparam int SS       = 2;
  localparam int SS_BITS  = 1;
  localparam int NUM_ARCH = 32;
  localparam int NUM_PHYS = 64;
  localparam int FL_DEPTH = 32;
  localparam int FL_BITS  = 5;

  logic clk = 1'b0;
  logic rst;
  logic [SS_BITS:0] commit_cnt;
  logic [4:0]       rrf_arch_reg [SS];
  logic [5:0]       rrf_phys_reg [SS];
  logic             mispredict;
  logic [SS_BITS:0] alloc_cnt;
  logic [5:0]       alloc_phys [SS];
  logic [FL_BITS:0] free_count;
  logic [5:0]       rrf_map [NUM_ARCH];

  rrf_free_list #(.SS(SS), .SS_BITS(SS_BITS), .NUM_ARCH(NUM_ARCH), .NUM_PHYS(NUM_PHYS)) dut (
    .clk(clk), .rst(rst), .commit_cnt(commit_cnt), .rrf_arch_reg(rrf_arch_reg),
    .rrf_phys_reg(rrf_phys_reg), .mispredict(mispredict), .alloc_cnt(alloc_cnt),
    .alloc_phys(alloc_phys), .free_count(free_count), .rrf_map(rrf_map)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [FL_BITS:0] fc; logic [5:0] ap0; logic [5:0] ap1; } exp_t;
  typedef struct packed { logic [4:0] arch; logic [5:0] phys; } inst_t;

  exp_t  sb[$];
  inst_t inflight[$];
  int    m_map [NUM_ARCH];
  int    m_fl  [FL_DEPTH];
  int    m_head, m_tail;
  int    lane_arch [SS];
  int    lane_phys [SS];
  int    errors = 0;
  int    checks = 0;

  function automatic exp_t model_outputs();
    exp_t e;
    e.fc  = (FL_BITS+1)'(m_tail - m_head);
    e.ap0 = 6'(m_fl[m_head % FL_DEPTH]);
    e.ap1 = 6'(m_fl[(m_head + 1) % FL_DEPTH]);
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_ARCH; i++) m_map[i] = i;
    for (int j = 0; j < FL_DEPTH; j++) m_fl[j] = NUM_ARCH + j;
    m_head = 0;
    m_tail = FL_DEPTH;
    inflight.delete();
  endtask

  task automatic chk_const(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_cycle(input string tag);
    exp_t e;
    int   bad;
    int   seen [NUM_PHYS];
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s scoreboard: got 0 entries expected 1", tag);
    end
    if (sb.size() == 0) return;
    e = sb.pop_front();
    checks++;
    assert (free_count === e.fc) else begin
      errors++;
      $error("FAIL %s free_count: got %0d expected %0d", tag, free_count, e.fc);
    end
    checks++;
    assert (alloc_phys[0] === e.ap0) else begin
      errors++;
      $error("FAIL %s alloc_phys0: got %0d expected %0d", tag, alloc_phys[0], e.ap0);
    end
    checks++;
    assert (alloc_phys[1] === e.ap1) else begin
      errors++;
      $error("FAIL %s alloc_phys1: got %0d expected %0d", tag, alloc_phys[1], e.ap1);
    end
    bad = -1;
    for (int k = 0; k < NUM_ARCH; k++)
      if (rrf_map[k] !== 6'(m_map[k]) && bad < 0) bad = k;
    checks++;
    assert (bad < 0) else begin
      errors++;
      $error("FAIL %s rrf_map[%0d]: got %0d expected %0d", tag, bad, rrf_map[bad], m_map[bad]);
    end
    // Every phys reg must sit in exactly one of: committed map, free window, in flight.
    for (int p = 0; p < NUM_PHYS; p++) seen[p] = 0;
    for (int k = 0; k < NUM_ARCH; k++) seen[rrf_map[k]]++;
    for (int q = m_head; q < m_tail; q++) seen[m_fl[q % FL_DEPTH]]++;
    foreach (inflight[q]) seen[inflight[q].phys]++;
    bad = -1;
    for (int p = 0; p < NUM_PHYS; p++)
      if (seen[p] != 1 && bad < 0) bad = p;
    checks++;
    assert (bad < 0) else begin
      errors++;
      $error("FAIL %s invariant phys %0d: count %0d expected 1", tag, bad, seen[bad]);
    end
  endtask

  task automatic do_reset(input int cycles, input bit noisy);
    rst        = 1'b1;
    commit_cnt = noisy ? 2'd2 : 2'd0;
    alloc_cnt  = noisy ? 2'd2 : 2'd0;
    mispredict = noisy;
    for (int i = 0; i < SS; i++) begin
      rrf_arch_reg[i] = noisy ? 5'(i + 7) : 5'd0;
      rrf_phys_reg[i] = 6'(i + 1);
    end
    model_reset();
    sb.push_back(model_outputs());
    repeat (cycles) @(posedge clk);
    #1;
    rst        = 1'b0;
    commit_cnt = '0;
    alloc_cnt  = '0;
    mispredict = 1'b0;
    check_cycle(noisy ? "reset_midop" : "reset");
  endtask

  task automatic step(input int cc, input bit misp, input int ac,
                      input int aa0, input int aa1, input string tag);
    int    cnt0;
    int    got [SS];
    int    aa  [SS];
    inst_t t;
    commit_cnt = (SS_BITS+1)'(cc);
    alloc_cnt  = (SS_BITS+1)'(ac);
    mispredict = misp;
    for (int i = 0; i < SS; i++) begin
      rrf_arch_reg[i] = 5'(lane_arch[i]);
      rrf_phys_reg[i] = 6'(lane_phys[i]);
    end
    cnt0  = m_tail - m_head;
    aa[0] = aa0;
    aa[1] = aa1;
    for (int i = 0; i < SS; i++) got[i] = m_fl[(m_head + i) % FL_DEPTH];
    for (int i = 0; i < cc; i++) begin
      if (lane_arch[i] != 0) begin
        m_fl[m_tail % FL_DEPTH] = m_map[lane_arch[i]];
        m_map[lane_arch[i]]     = lane_phys[i];
        m_tail++;
      end
    end
    if (misp) begin
      m_head = m_tail - FL_DEPTH;
      inflight.delete();
    end else if (ac <= cnt0) begin
      for (int i = 0; i < ac; i++) begin
        t.arch = 5'(aa[i]);
        t.phys = 6'(got[i]);
        inflight.push_back(t);
      end
      m_head += ac;
    end
    sb.push_back(model_outputs());
    @(posedge clk);
    #1;
    check_cycle(tag);
  endtask

  // Lanes below n commit the oldest in-flight regs (or branches); lanes above n carry junk.
  task automatic commit_step(input int n, input int bmask, input bit misp, input int ac,
                             input int aa0, input int aa1, input string tag);
    inst_t t;
    for (int i = 0; i < SS; i++) begin
      lane_arch[i] = $urandom_range(1, 31);
      lane_phys[i] = $urandom_range(0, 63);
      if (i < n) begin
        if (bmask[i] || inflight.size() == 0) begin
          lane_arch[i] = 0;
        end else begin
          t = inflight.pop_front();
          lane_arch[i] = int'(t.arch);
          lane_phys[i] = int'(t.phys);
        end
      end
    end
    step(n, misp, ac, aa0, aa1, tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    do_reset(2, 1'b0);
    chk_const("t1_free_count", int'(free_count), 32);
    chk_const("t1_alloc0", int'(alloc_phys[0]), 32);
    chk_const("t1_alloc1", int'(alloc_phys[1]), 33);
    chk_const("t1_map5", int'(rrf_map[5]), 5);

    commit_step(0, 0, 1'b0, 2, 5, 6, "t2_alloc");
    commit_step(2, 0, 1'b0, 0, 1, 1, "t2_commit");
    chk_const("t2_map5", int'(rrf_map[5]), 32);
    chk_const("t2_map6", int'(rrf_map[6]), 33);
    chk_const("t2_free_count", int'(free_count), 32);

    commit_step(0, 0, 1'b0, 2, 7, 7, "t3_alloc");
    commit_step(2, 0, 1'b0, 0, 1, 1, "t3_commit");
    chk_const("t3_map7", int'(rrf_map[7]), 35);

    commit_step(0, 0, 1'b0, 1, 3, 1, "t4_alloc");
    chk_const("t4_free_before", int'(free_count), 31);
    commit_step(2, 1, 1'b0, 0, 1, 1, "t4_commit");
    chk_const("t4_free_after", int'(free_count), 32);
    chk_const("t4_map3", int'(rrf_map[3]), 36);

    for (int k = 0; k < 5; k++)
      commit_step(0, 0, 1'b0, 2, $urandom_range(1, 31), $urandom_range(1, 31), "t5_alloc");
    commit_step(2, 0, 1'b0, 0, 1, 1, "t5_commit");
    commit_step(1, 1, 1'b1, 2, 1, 1, "t5_mispredict");
    chk_const("t5_free_count", int'(free_count), 32);

    for (int k = 0; k < 16; k++)
      commit_step(0, 0, 1'b0, 2, $urandom_range(1, 31), $urandom_range(1, 31), "t6_drain");
    chk_const("t6_empty", int'(free_count), 0);
    commit_step(0, 0, 1'b0, 2, 4, 4, "t6_overalloc");
    chk_const("t6_overalloc_count", int'(free_count), 0);

    for (int it = 0; it < 250; it++) begin
      int n, ac, bm;
      bit misp;
      n    = ($urandom_range(0, 9) < 6) ? 2 : $urandom_range(0, 1);
      ac   = ($urandom_range(0, 9) < 7) ? 2 : $urandom_range(0, 1);
      bm   = (($urandom_range(0, 4) == 0) ? 1 : 0) | (($urandom_range(0, 4) == 0) ? 2 : 0);
      misp = ($urandom_range(0, 39) == 0);
      commit_step(n, bm, misp, ac, $urandom_range(1, 31), $urandom_range(1, 31), "t6_random");
    end

    do_reset(1, 1'b1);
    chk_const("t7_free_count", int'(free_count), 32);
    chk_const("t7_map7", int'(rrf_map[7]), 7);
    commit_step(0, 0, 1'b0, 2, 9, 10, "t7_alloc");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
